// File: rtl/text_cmd_ctrl.sv
// UART byte-command decoder for a text screen buffer: col, row, char, terminator writes one cell; 0x80 clears the screen.
// Writes appear the cycle after the byte event; bytes arriving during a clear are dropped and flagged on ovr_o.
module text_cmd_ctrl #(
  parameter int N_COL         = 80,
  parameter int N_ROW         = 30,
  parameter int N_COL_WIDTH   = 7,
  parameter int N_ROW_WIDTH   = 5,
  parameter int N_CHARS_WIDTH = 7,
  parameter logic [N_CHARS_WIDTH-1:0] CLEAR_CHAR = 7'h20
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     rx_valid_i,
  input  logic [7:0]               rx_data_i,
  output logic                     wr_en_o,
  output logic [N_COL_WIDTH-1:0]   col_w_o,
  output logic [N_ROW_WIDTH-1:0]   row_w_o,
  output logic [N_CHARS_WIDTH-1:0] din_o,
  output logic                     busy_o,
  output logic                     err_o,
  output logic                     ovr_o
);

  typedef enum logic [2:0] {S_COL, S_ROW, S_DATA, S_TERM, S_CLEAR} state_t;

  state_t                 state;
  logic                   rx_valid_q;
  logic                   discard;
  logic                   clr_last;
  logic [N_COL_WIDTH-1:0] col, clr_col, clr_col_nxt;
  logic [N_ROW_WIDTH-1:0] row, clr_row, clr_row_nxt;
  logic                   ev;
  logic                   clr_at_end;
  logic                   clr_issue;

  assign ev         = rx_valid_i & ~rx_valid_q;
  assign clr_at_end = (int'(clr_col) == N_COL - 1) && (int'(clr_row) == N_ROW - 1);
  // The clear counters always hold the next cell to write, so the first write can go out on the 0x80 edge itself.
  assign clr_issue  = ((state == S_COL) && ev && (rx_data_i == 8'h80)) ||
                      ((state == S_CLEAR) && !clr_last);

  always_comb begin
    clr_col_nxt = clr_col + 1'b1;
    clr_row_nxt = clr_row;
    if (int'(clr_col) == N_COL - 1) begin
      clr_col_nxt = '0;
      clr_row_nxt = (int'(clr_row) == N_ROW - 1) ? '0 : clr_row + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state      <= S_COL;
      rx_valid_q <= 1'b0;
      discard    <= 1'b0;
      clr_last   <= 1'b0;
      col        <= '0;
      row        <= '0;
      clr_col    <= '0;
      clr_row    <= '0;
      wr_en_o    <= 1'b0;
      col_w_o    <= '0;
      row_w_o    <= '0;
      din_o      <= '0;
      busy_o     <= 1'b0;
      err_o      <= 1'b0;
      ovr_o      <= 1'b0;
    end else begin
      rx_valid_q <= rx_valid_i;
      wr_en_o    <= 1'b0;
      err_o      <= 1'b0;
      ovr_o      <= 1'b0;
      case (state)
        S_COL: if (ev) begin
          if (rx_data_i[7]) begin
            if (rx_data_i == 8'h80) state <= S_CLEAR;
            else                    err_o <= 1'b1;
          end else begin
            col   <= (int'(rx_data_i[6:0]) >= N_COL) ? N_COL_WIDTH'(int'(rx_data_i[6:0]) - N_COL)
                                                     : N_COL_WIDTH'(rx_data_i[6:0]);
            state <= S_ROW;
          end
        end
        S_ROW: if (ev) begin
          row     <= N_ROW_WIDTH'(rx_data_i[4:0]);
          discard <= int'(rx_data_i[4:0]) >= N_ROW;
          err_o   <= int'(rx_data_i[4:0]) >= N_ROW;
          state   <= S_DATA;
        end
        S_DATA: if (ev) begin
          if (!discard) begin
            wr_en_o <= 1'b1;
            col_w_o <= col;
            row_w_o <= row;
            din_o   <= N_CHARS_WIDTH'(rx_data_i[6:0]);
          end
          state <= S_TERM;
        end
        S_TERM: if (ev) begin
          discard <= 1'b0;
          err_o   <= (rx_data_i != 8'h0A);
          state   <= S_COL;
        end
        S_CLEAR: begin
          if (ev) ovr_o <= 1'b1;
          if (clr_last) begin
            clr_last <= 1'b0;
            busy_o   <= 1'b0;
            state    <= S_COL;
          end
        end
        default: state <= S_COL;
      endcase
      if (clr_issue) begin
        wr_en_o  <= 1'b1;
        busy_o   <= 1'b1;
        col_w_o  <= clr_col;
        row_w_o  <= clr_row;
        din_o    <= CLEAR_CHAR;
        clr_col  <= clr_col_nxt;
        clr_row  <= clr_row_nxt;
        clr_last <= clr_at_end;
      end
    end
  end

endmodule

// File: tb/tb_text_cmd_ctrl.sv
// Directed bench for text_cmd_ctrl: single writes, column wrap, row discard, terminator error, clear and reset mid-clear.
module tb_text_cmd_ctrl;

  logic       clk = 1'b0;
  logic       rstn;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       wr_en, busy, err, ovr;
  logic [6:0] col_w;
  logic [4:0] row_w;
  logic [6:0] din;

  text_cmd_ctrl dut (
    .clk_i(clk), .rstn_i(rstn), .rx_valid_i(rx_valid), .rx_data_i(rx_data),
    .wr_en_o(wr_en), .col_w_o(col_w), .row_w_o(row_w), .din_o(din),
    .busy_o(busy), .err_o(err), .ovr_o(ovr)
  );

  always #20 clk = ~clk;

  int n_cmp = 0, n_fail = 0;
  int wr_cnt, err_cnt, ovr_cnt, clr_n, busy_cnt, order_err;
  int viol = 0;
  int last_col, last_row, last_din, first_col, first_row, exp_c, exp_r;
  logic prev_wr = 1'b0, prev_err = 1'b0, prev_ovr = 1'b0, prev_busy = 1'b0;

  // Observes the write port between clock edges and tracks the expected row-major clear sequence.
  always @(negedge clk) begin
    if (wr_en) begin
      wr_cnt++;
      last_col = col_w; last_row = row_w; last_din = din;
      if (busy) begin
        if (clr_n == 0) begin first_col = col_w; first_row = row_w; end
        if (col_w != exp_c || row_w != exp_r || din != 7'h20) order_err++;
        exp_c++;
        if (exp_c == 80) begin exp_c = 0; exp_r++; end
        clr_n++;
      end
    end
    if (busy) busy_cnt++;
    if (err) err_cnt++;
    if (ovr) ovr_cnt++;
    if ((wr_en && prev_wr && !busy && !prev_busy) || (err && prev_err) || (ovr && prev_ovr)) viol++;
    prev_wr = wr_en; prev_err = err; prev_ovr = ovr; prev_busy = busy;
  end

  task automatic clr_mon();
    wr_cnt = 0; err_cnt = 0; ovr_cnt = 0; clr_n = 0; busy_cnt = 0; order_err = 0;
    last_col = -1; last_row = -1; last_din = -1; first_col = -1; first_row = -1;
    exp_c = 0; exp_r = 0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk); rx_valid = 1'b1; rx_data = b;
    @(negedge clk); rx_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rstn = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    clr_mon();
    repeat (3) @(negedge clk);
    n_cmp++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en got=%b want=0", wr_en); end
    n_cmp++; if ({busy, err, ovr} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got=%b want=000", {busy, err, ovr}); end
    n_cmp++; if ({col_w, row_w, din} !== 19'd0) begin n_fail++; $display("FAIL reset_bus got=%h want=0", {col_w, row_w, din}); end
    rstn = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    clr_mon();
    send_byte(8'h05); send_byte(8'h03); send_byte(8'h41); send_byte(8'h0A);
    repeat (3) @(negedge clk);
    n_cmp++; if (wr_cnt !== 1) begin n_fail++; $display("FAIL basic_wr_cnt got=%0d want=1", wr_cnt); end
    n_cmp++; if (last_col !== 5 || last_row !== 3) begin n_fail++; $display("FAIL basic_pos got=%0d,%0d want=5,3", last_col, last_row); end
    n_cmp++; if (last_din !== 'h41) begin n_fail++; $display("FAIL basic_din got=%h want=41", last_din); end
    n_cmp++; if (err_cnt !== 0 || ovr_cnt !== 0) begin n_fail++; $display("FAIL basic_err_ovr got=%0d/%0d want=0/0", err_cnt, ovr_cnt); end
    n_cmp++; if (col_w !== 7'd5 || row_w !== 5'd3 || din !== 7'h41) begin n_fail++; $display("FAIL basic_hold got=%0d,%0d,%h want=5,3,41", col_w, row_w, din); end
  endtask

  task automatic test_col_wrap();
    clr_mon();
    send_byte(8'h52); send_byte(8'h1D); send_byte(8'h42); send_byte(8'h0A);
    repeat (3) @(negedge clk);
    n_cmp++; if (wr_cnt !== 1) begin n_fail++; $display("FAIL wrap_wr_cnt got=%0d want=1", wr_cnt); end
    n_cmp++; if (last_col !== 2 || last_row !== 29 || last_din !== 'h42) begin n_fail++; $display("FAIL wrap_write got=%0d,%0d,%h want=2,29,42", last_col, last_row, last_din); end
    n_cmp++; if (err_cnt !== 0) begin n_fail++; $display("FAIL wrap_err got=%0d want=0", err_cnt); end
  endtask

  task automatic test_discard();
    clr_mon();
    send_byte(8'h01); send_byte(8'h1F);
    n_cmp++; if (err_cnt !== 1) begin n_fail++; $display("FAIL discard_err_after_row got=%0d want=1", err_cnt); end
    send_byte(8'h43); send_byte(8'h0A);
    repeat (2) @(negedge clk);
    n_cmp++; if (wr_cnt !== 0) begin n_fail++; $display("FAIL discard_no_write got=%0d want=0", wr_cnt); end
    n_cmp++; if (err_cnt !== 1) begin n_fail++; $display("FAIL discard_err_total got=%0d want=1", err_cnt); end
    send_byte(8'h07); send_byte(8'h04); send_byte(8'h45); send_byte(8'h0A);
    repeat (2) @(negedge clk);
    n_cmp++; if (wr_cnt !== 1 || last_col !== 7 || last_row !== 4 || last_din !== 'h45) begin n_fail++; $display("FAIL discard_recover got=%0d:%0d,%0d,%h want=1:7,4,45", wr_cnt, last_col, last_row, last_din); end
  endtask

  task automatic test_term_err();
    clr_mon();
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h44);
    n_cmp++; if (wr_cnt !== 1 || err_cnt !== 0) begin n_fail++; $display("FAIL term_write_first got=%0d/%0d want=1/0", wr_cnt, err_cnt); end
    send_byte(8'h0D);
    repeat (2) @(negedge clk);
    n_cmp++; if (err_cnt !== 1) begin n_fail++; $display("FAIL term_err got=%0d want=1", err_cnt); end
    n_cmp++; if (wr_cnt !== 1 || last_col !== 1 || last_row !== 2 || last_din !== 'h44) begin n_fail++; $display("FAIL term_write got=%0d:%0d,%0d,%h want=1:1,2,44", wr_cnt, last_col, last_row, last_din); end
  endtask

  task automatic test_clear();
    int i;
    clr_mon();
    @(negedge clk); rx_valid = 1'b1; rx_data = 8'h80;
    n_cmp++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL clear_pre got=%b want=0", wr_en); end
    @(negedge clk); rx_valid = 1'b0;
    n_cmp++; if (wr_en !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL clear_first_cycle got=%b%b want=11", wr_en, busy); end
    i = 0;
    while (busy && i < 3000) begin
      @(negedge clk);
      if (i == 300) begin rx_valid = 1'b1; rx_data = 8'h33; end
      if (i == 302) rx_valid = 1'b0;
      i++;
    end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL clear_timeout busy=%b after %0d cycles want=0", busy, i); end
    repeat (2) @(negedge clk);
    n_cmp++; if (clr_n !== 2400 || wr_cnt !== 2400) begin n_fail++; $display("FAIL clear_count got=%0d/%0d want=2400", clr_n, wr_cnt); end
    n_cmp++; if (busy_cnt !== 2400) begin n_fail++; $display("FAIL clear_busy got=%0d want=2400", busy_cnt); end
    n_cmp++; if (first_col !== 0 || first_row !== 0) begin n_fail++; $display("FAIL clear_first got=%0d,%0d want=0,0", first_col, first_row); end
    n_cmp++; if (last_col !== 79 || last_row !== 29 || last_din !== 'h20) begin n_fail++; $display("FAIL clear_last got=%0d,%0d,%h want=79,29,20", last_col, last_row, last_din); end
    n_cmp++; if (order_err !== 0) begin n_fail++; $display("FAIL clear_order got=%0d bad want=0", order_err); end
    n_cmp++; if (ovr_cnt !== 1 || err_cnt !== 0) begin n_fail++; $display("FAIL clear_ovr got=%0d/%0d want=1/0", ovr_cnt, err_cnt); end
    send_byte(8'h03); send_byte(8'h04); send_byte(8'h46); send_byte(8'h0A);
    repeat (2) @(negedge clk);
    n_cmp++; if (wr_cnt !== 2401 || last_col !== 3 || last_row !== 4 || last_din !== 'h46) begin n_fail++; $display("FAIL clear_then_cmd got=%0d:%0d,%0d,%h want=2401:3,4,46", wr_cnt, last_col, last_row, last_din); end
  endtask

  task automatic test_reset_mid_clear();
    int i;
    clr_mon();
    send_byte(8'h80);
    i = 0;
    while (clr_n < 1000 && i < 3000) begin @(posedge clk); #5; i++; end
    n_cmp++; if (clr_n < 1000) begin n_fail++; $display("FAIL midclr_timeout got=%0d writes want=1000", clr_n); end
    rstn = 1'b0;
    #1;
    n_cmp++; if (wr_en !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL midclr_flags got=%b%b want=00", wr_en, busy); end
    n_cmp++; if ({col_w, row_w, din} !== 19'd0) begin n_fail++; $display("FAIL midclr_bus got=%h want=0", {col_w, row_w, din}); end
    rx_valid = 1'b1; rx_data = 8'h0B;
    @(negedge clk); clr_mon();
    @(negedge clk); rstn = 1'b1;
    @(negedge clk); rx_valid = 1'b0;
    @(negedge clk);
    send_byte(8'h0A); send_byte(8'h47); send_byte(8'h0A);
    repeat (2) @(negedge clk);
    n_cmp++; if (wr_cnt !== 1 || last_col !== 11 || last_row !== 10 || last_din !== 'h47) begin n_fail++; $display("FAIL midclr_next_cmd got=%0d:%0d,%0d,%h want=1:11,10,47", wr_cnt, last_col, last_row, last_din); end
    n_cmp++; if (err_cnt !== 0 || ovr_cnt !== 0 || clr_n !== 0) begin n_fail++; $display("FAIL midclr_quiet got=%0d/%0d/%0d want=0/0/0", err_cnt, ovr_cnt, clr_n); end
  endtask

  task automatic test_pulse_rules();
    n_cmp++; if (viol !== 0) begin n_fail++; $display("FAIL pulse_rules got=%0d violations want=0", viol); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_col_wrap();
    test_discard();
    test_term_err();
    test_clear();
    test_reset_mid_clear();
    test_pulse_rules();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
